// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared definitions for the MIPS memory-access stage.
//                Holds the opcode set (existing ALU/branch opcodes plus the
//                load/store opcodes), the FSM state encoding, the lane-size
//                enum and small opcode decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Existing opcode set
    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_j       = 6'h02;
    localparam logic [5:0] c_op_beq     = 6'h04;
    localparam logic [5:0] c_op_addi    = 6'h08;
    localparam logic [5:0] c_op_addiu   = 6'h09;
    localparam logic [5:0] c_op_andi    = 6'h0C;
    localparam logic [5:0] c_op_ori     = 6'h0D;
    localparam logic [5:0] c_op_lui     = 6'h0F;

    // Loads
    localparam logic [5:0] c_op_lb      = 6'h20;
    localparam logic [5:0] c_op_lh      = 6'h21;
    localparam logic [5:0] c_op_lw      = 6'h23;
    localparam logic [5:0] c_op_lbu     = 6'h24;
    localparam logic [5:0] c_op_lhu     = 6'h25;

    // Stores
    localparam logic [5:0] c_op_sb      = 6'h28;
    localparam logic [5:0] c_op_sh      = 6'h29;
    localparam logic [5:0] c_op_sw      = 6'h2B;

    // FSM state encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_access  = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lane_size_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == c_op_lb) || (op == c_op_lh) || (op == c_op_lw) ||
               (op == c_op_lbu) || (op == c_op_lhu);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == c_op_sb) || (op == c_op_sh) || (op == c_op_sw);
    endfunction

    function automatic lane_size_e op_size(input logic [5:0] op);
        if ((op == c_op_lb) || (op == c_op_lbu) || (op == c_op_sb)) begin
            return BYTE;
        end else if ((op == c_op_lh) || (op == c_op_lhu) || (op == c_op_sh)) begin
            return HALF;
        end
        return WORD;
    endfunction

    // Only LB and LH sign-extend; everything else is zero-extended or full word.
    function automatic logic op_signed(input logic [5:0] op);
        return (op == c_op_lb) || (op == c_op_lh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane
//  Description : Combinational big-endian lane logic for the memory stage.
//                Generates byte enables and the replicated store data,
//                flags misaligned accesses, and extracts/extends load data.
//  Ports       : size       - access size (BYTE/HALF/WORD)
//                sign_ext   - sign-extend the loaded value
//                addr_lo    - effective address bits [1:0]
//                store_data - rt value to be stored
//                load_data  - raw word returned by memory
//                misaligned - access violates its natural alignment
//                be         - byte enables, be[3] is byte 0
//                wdata      - lane-aligned store data
//                load_value - extracted and extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane
    import mem_stage_pkg::*;
(
    input  lane_size_e  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte n of the word lives at bits [31-8n -: 8].
    always_comb begin
        w_byte = load_data[31:24];
        case (addr_lo)
            2'd0:    w_byte = load_data[31:24];
            2'd1:    w_byte = load_data[23:16];
            2'd2:    w_byte = load_data[15:8];
            default: w_byte = load_data[7:0];
        endcase
        w_half = addr_lo[1] ? load_data[15:0] : load_data[31:16];
    end

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = store_data;
        load_value = load_data;
        case (size)
            BYTE: begin
                be         = 4'b1000 >> addr_lo;
                // Replicating across all lanes lets the enables pick the slot.
                wdata      = {4{store_data[7:0]}};
                load_value = {{24{sign_ext & w_byte[7]}}, w_byte};
            end
            HALF: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{store_data[15:0]}};
                load_value = {{16{sign_ext & w_half[15]}}, w_half};
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS memory-access stage. Non-memory instructions pass the
//                ALU result straight to write-back; loads and stores run a
//                req/ack transaction against data memory with an ack timeout.
//  Ports       : CLK, RST            - clock / async active-high reset
//                Ins, Result, Rdata2 - instruction, ALU result, store data
//                valid_in            - execute-stage outputs are valid
//                stall               - hold upstream stages
//                mem_req/we/addr/be/wdata, mem_ack/rdata - memory bus
//                Wdata, wb_valid     - write-back value and strobe
//                addr_err, bus_err   - misalignment / timeout pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic        valid_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Wdata,
    output logic        wb_valid,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [1:0]         state_q,    state_d;
    logic [c_cnt_w-1:0] cnt_q,      cnt_d;
    logic [5:0]         op_q,       op_d;
    logic [1:0]         lo_q,       lo_d;
    logic [31:0]        addr_q,     addr_d;
    logic [3:0]         be_q,       be_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic               we_q,       we_d;
    logic [31:0]        wb_data_q,  wb_data_d;
    logic               wb_valid_q, wb_valid_d;
    logic               addr_err_q, addr_err_d;
    logic               bus_err_q,  bus_err_d;

    logic        w_idle;
    logic [5:0]  w_op;
    logic [1:0]  w_lo;
    logic        w_is_mem;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_value;
    logic        w_unused_ins;

    // Only the opcode field matters to this stage.
    assign w_unused_ins = ^Ins[25:0];

    assign w_idle   = (state_q == c_st_idle);
    // The lane logic decodes the incoming instruction in IDLE and the
    // captured one while a transaction is in flight.
    assign w_op     = w_idle ? Ins[31:26]  : op_q;
    assign w_lo     = w_idle ? Result[1:0] : lo_q;
    assign w_is_mem = is_load(w_op) | is_store(w_op);

    mem_lane u_mem_lane (
        .size       (op_size(w_op)),
        .sign_ext   (op_signed(w_op)),
        .addr_lo    (w_lo),
        .store_data (Rdata2),
        .load_data  (mem_rdata),
        .misaligned (w_misaligned),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_value (w_load_value)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        lo_d       = lo_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (valid_in) begin
                    if (!w_is_mem) begin
                        wb_data_d  = Result;
                        wb_valid_d = 1'b1;
                    end else if (w_misaligned) begin
                        addr_err_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_data_d  = 32'h0;
                    end else begin
                        op_d    = w_op;
                        lo_d    = Result[1:0];
                        addr_d  = {Result[31:2], 2'b00};
                        be_d    = w_be;
                        wdata_d = w_wdata;
                        we_d    = is_store(w_op);
                        cnt_d   = '0;
                        state_d = c_st_access;
                    end
                end
            end
            c_st_access: begin
                // Ack is checked first so a late ack on the final cycle wins.
                if (mem_ack) begin
                    wb_data_d = we_q ? 32'h0 : w_load_value;
                    state_d   = c_st_done;
                end else if (cnt_q == c_cnt_last) begin
                    bus_err_d = 1'b1;
                    wb_data_d = 32'h0;
                    state_d   = c_st_done;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            c_st_done: begin
                wb_valid_d = 1'b1;
                state_d    = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= c_st_idle;
            cnt_q      <= '0;
            op_q       <= 6'h0;
            lo_q       <= 2'b00;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            wb_data_q  <= 32'h0;
            wb_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall     = !w_idle | (valid_in & w_is_mem & !w_misaligned);
    assign mem_req   = (state_q == c_st_access);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign Wdata     = wb_data_q;
    assign wb_valid  = wb_valid_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. A table of directed
//                instruction vectors with hand-computed bus and write-back
//                values, plus hand-written reset, busy and abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int c_tmo = 6;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins, Result, Rdata2, mem_rdata;
    logic        valid_in, mem_ack;
    logic        stall, mem_req, mem_we, wb_valid, addr_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, Wdata;
    logic [3:0]  mem_be;

    always #5 CLK = ~CLK;

    mem_stage #(.TIMEOUT(c_tmo)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .valid_in(valid_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Wdata(Wdata),
        .wb_valid(wb_valid), .addr_err(addr_err), .bus_err(bus_err)
    );

    // ack_at: ACCESS cycle (1-based) in which ack is driven, 0 = never.
    // lat:    cycles from valid_in edge to wb_valid, 0 = not checked.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, rt, rdata;
        int          ack_at;
        logic        req, we;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata;
        logic        chk_mw;
        logic [31:0] wdata;
        logic        aerr, berr;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rdata, input int ack_at, input logic req,
                       input logic we, input logic [3:0] be, input logic [31:0] maddr,
                       input logic [31:0] mwdata, input logic chk_mw, input logic [31:0] wdata,
                       input logic aerr, input logic berr, input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.ack_at = ack_at;
        v.req = req; v.we = we; v.be = be; v.maddr = maddr; v.mwdata = mwdata;
        v.chk_mw = chk_mw; v.wdata = wdata; v.aerr = aerr; v.berr = berr; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; returns at the same phase of the wb cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat, reqc;
        logic seen_req, got_wb, ae, be_seen;
        lat = 0; reqc = 0; seen_req = 1'b0; got_wb = 1'b0; ae = 1'b0; be_seen = 1'b0;
        Ins       = {v.op, 20'h0, 6'h21};
        Result    = v.addr;
        Rdata2    = v.rt;
        mem_rdata = v.rdata;
        mem_ack   = 1'b0;
        valid_in  = 1'b1;
        #1;
        chk($sformatf("v%0d stall_at_issue", idx), {31'h0, stall}, {31'h0, v.req});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge CLK);
            #1;
            valid_in = 1'b0;
            mem_ack  = 1'b0;
            if (addr_err) ae = 1'b1;
            if (bus_err)  be_seen = 1'b1;
            if (mem_req) begin
                if (!seen_req) begin
                    seen_req = 1'b1;
                    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.maddr);
                    chk($sformatf("v%0d mem_be", idx), {28'h0, mem_be}, {28'h0, v.be});
                    chk($sformatf("v%0d mem_we", idx), {31'h0, mem_we}, {31'h0, v.we});
                    if (v.chk_mw) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwdata);
                end
                reqc++;
                if (reqc == v.ack_at) mem_ack = 1'b1;
            end
            if (wb_valid) begin
                got_wb = 1'b1;
                lat    = cyc;
                break;
            end
        end
        chk($sformatf("v%0d wb_seen", idx), {31'h0, got_wb}, 32'h1);
        chk($sformatf("v%0d Wdata", idx), Wdata, v.wdata);
        chk($sformatf("v%0d req_issued", idx), {31'h0, seen_req}, {31'h0, v.req});
        chk($sformatf("v%0d addr_err", idx), {31'h0, ae}, {31'h0, v.aerr});
        chk($sformatf("v%0d bus_err", idx), {31'h0, be_seen}, {31'h0, v.berr});
        chk($sformatf("v%0d req_low_at_wb", idx), {31'h0, mem_req}, 32'h0);
        if (v.lat != 0) chk($sformatf("v%0d latency", idx), lat, v.lat);
    endtask

    initial begin
        logic flag;
        vec_t v;
        RST = 1'b1; Ins = '0; Result = '0; Rdata2 = '0; mem_rdata = '0;
        valid_in = 1'b0; mem_ack = 1'b0;

        //   op      addr          rt            rdata        ack req we be       maddr         mwdata        cmw Wdata         ae be lat
        add(6'h00, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h1234_5678, 0, 0, 1);
        add(6'h20, 32'h0000_0101, 32'h0,        32'h11F2_3344, 1, 1, 0, 4'b0100, 32'h100,     32'h0,        0, 32'hFFFF_FFF2, 0, 0, 3);
        add(6'h24, 32'h0000_0101, 32'h0,        32'h11F2_3344, 1, 1, 0, 4'b0100, 32'h100,     32'h0,        0, 32'h0000_00F2, 0, 0, 3);
        add(6'h29, 32'h0000_0202, 32'hAAAA_BEEF, 32'hFFFF_FFFF, 1, 1, 1, 4'b0011, 32'h200,     32'hBEEF_BEEF, 1, 32'h0,        0, 0, 3);
        add(6'h23, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,         1, 0, 1);
        add(6'h21, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,         1, 0, 1);
        add(6'h21, 32'h0000_0000, 32'h0,        32'h8001_1234, 1, 1, 0, 4'b1100, 32'h0,       32'h0,        0, 32'hFFFF_8001, 0, 0, 3);
        add(6'h25, 32'h0000_0002, 32'h0,        32'h1234_F00D, 1, 1, 0, 4'b0011, 32'h0,       32'h0,        0, 32'h0000_F00D, 0, 0, 3);
        add(6'h20, 32'h0000_0002, 32'h0,        32'h1122_3344, 1, 1, 0, 4'b0010, 32'h0,       32'h0,        0, 32'h0000_0033, 0, 0, 3);
        add(6'h28, 32'h0000_0003, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1, 1, 4'b0001, 32'h0,       32'hA5A5_A5A5, 1, 32'h0,        0, 0, 3);
        add(6'h2B, 32'h0000_0010, 32'hCAFE_BABE, 32'hFFFF_FFFF, 1, 1, 1, 4'b1111, 32'h10,      32'hCAFE_BABE, 1, 32'h0,        0, 0, 3);
        add(6'h23, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, 3, 1, 0, 4'b1111, 32'h300,     32'h0,        0, 32'hDEAD_BEEF, 0, 0, 5);
        add(6'h23, 32'h0000_0304, 32'h0,        32'h5555_AAAA, 0, 1, 0, 4'b1111, 32'h304,     32'h0,        0, 32'h0,         0, 1, 0);
        add(6'h23, 32'h0000_0308, 32'h0,        32'h1357_2468, c_tmo, 1, 0, 4'b1111, 32'h308, 32'h0,        0, 32'h1357_2468, 0, 0, c_tmo + 2);
        add(6'h09, 32'hFFFF_0000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'hFFFF_0000, 0, 0, 1);
        add(6'h29, 32'h0000_0203, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,         1, 0, 1);

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst mem_req",   {31'h0, mem_req},  32'h0);
        chk("rst mem_we",    {31'h0, mem_we},   32'h0);
        chk("rst mem_addr",  mem_addr,          32'h0);
        chk("rst mem_be",    {28'h0, mem_be},   32'h0);
        chk("rst mem_wdata", mem_wdata,         32'h0);
        chk("rst Wdata",     Wdata,             32'h0);
        chk("rst pulses",    {29'h0, wb_valid, addr_err, bus_err}, 32'h0);
        chk("rst stall",     {31'h0, stall},    32'h0);
        RST = 1'b0;

        // Ack outside ACCESS is ignored
        mem_ack = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (wb_valid || mem_req || bus_err || stall) flag = 1'b1;
        end
        mem_ack = 1'b0;
        chk("stray_ack_ignored", {31'h0, flag}, 32'h0);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Wdata holds between write-backs (last vector wrote 0 via addr_err)
        repeat (3) @(posedge CLK);
        #1;
        chk("Wdata_hold", Wdata, 32'h0);
        chk("no_wb_idle", {31'h0, wb_valid}, 32'h0);

        // valid_in held while busy with a different instruction is ignored
        Ins = {6'h23, 26'h0}; Result = 32'h500; Rdata2 = 32'h0;
        mem_rdata = 32'h0000_0055; valid_in = 1'b1;
        flag = 1'b0;
        @(posedge CLK); #1;
        Ins = {6'h00, 20'h0, 6'h21}; Result = 32'h0000_0077;
        @(posedge CLK); #1;
        mem_ack = 1'b1;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        @(posedge CLK); #1;
        chk("busy wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("busy Wdata", Wdata, 32'h0000_0055);
        valid_in = 1'b0;
        @(posedge CLK); #1;
        chk("busy no_extra_wb", {31'h0, wb_valid}, 32'h0);

        // RST during ACCESS aborts at once with no write-back
        Ins = {6'h23, 26'h0}; Result = 32'h400; mem_rdata = 32'h0; valid_in = 1'b1;
        @(posedge CLK); #1;
        valid_in = 1'b0;
        chk("abort req_before", {31'h0, mem_req}, 32'h1);
        RST = 1'b1;
        #1;
        chk("abort req_dropped", {31'h0, mem_req}, 32'h0);
        chk("abort stall", {31'h0, stall}, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        flag = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (wb_valid || mem_req) flag = 1'b1;
        end
        chk("abort no_wb", {31'h0, flag}, 32'h0);
        v = vecs[1];
        v.addr = 32'h0000_0040; v.maddr = 32'h40; v.be = 4'b1000;
        v.rdata = 32'h8BAD_F00D; v.wdata = 32'hFFFF_FF8B;
        run_vec(v, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS datapath, directly downstream of the execute stage. It takes the executed instruction word, the ALU result (effective address or arithmetic result) and the rt operand (store data). Load and store instructions are carried out against an external data memory over a req/ack handshake, and every instruction leaves with a registered write-back value. While a memory transaction is outstanding, the block asserts `stall` so that upstream stages hold.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles to wait for `mem_ack` before the access is aborted with `bus_err`.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `Ins` in 32: instruction word from execute; opcode is `Ins[31:26]`.
- `Result` in 32: ALU result from execute; this is the effective address for loads and stores.
- `Rdata2` in 32: rt value, used as store data.
- `valid_in` in 1: the `Ins`/`Result`/`Rdata2` inputs are valid this cycle.
- `stall` out 1: upstream must hold its inputs stable.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write (1) or read (0).
- `mem_addr` out 32: word address, with `[1:0]` forced to 0.
- `mem_be` out 4: byte enables; `be[3]` = byte 0 (big-endian).
- `mem_wdata` out 32: lane-aligned store data.
- `mem_ack` in 1: memory completion; read data is valid in the same cycle.
- `mem_rdata` in 32: read data.
- `Wdata` out 32: write-back value.
- `wb_valid` out 1: one-cycle pulse when `Wdata` is valid.
- `addr_err` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on an ack timeout.

## Operation
- Memory opcodes:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Any other opcode is a non-memory instruction.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Valid non-memory instruction: `Wdata` <= `Result`, `wb_valid` <= 1, stay in IDLE.
  - Valid memory instruction, misaligned (half-word with `addr[0]`=1, or word with `addr[1:0]`≠0):
    - `addr_err` pulses and `wb_valid` pulses with `Wdata` = 0.
    - No request is issued; stay in IDLE.
  - Valid memory instruction, aligned:
    - Register the address, lane data, enables and opcode.
    - Go to ACCESS; clear the timeout counter.
- ACCESS:
  - `mem_req`=1, and all `mem_*` outputs are held stable.
  - On `mem_ack`:
    - Capture the extracted load value, or 0 for a store.
    - Go to DONE.
  - When the counter reaches `TIMEOUT` without `mem_ack`:
    - `bus_err` pulses and `Wdata` = 0.
    - Go to DONE.
- DONE: `wb_valid` pulses; go to IDLE.
- Lane mapping is big-endian; byte n = `addr[1:0]`.
  - Byte accesses: `be` = 4'b1000 >> n; data is taken from / placed at bits [31-8n -: 8].
  - Half-word accesses: `be` = 4'b1100 for n=0, 4'b0011 for n=2.
  - Word accesses: `be` = 4'b1111.
- Stores replicate the source byte or half across all lanes.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
- Loads drive `mem_we`=0 with `be` as for the matching store size.
- `stall` (combinational) = (state≠IDLE) | (`valid_in` & aligned memory opcode & state==IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- `RST` asserted mid-access aborts immediately: `mem_req` drops and there is no write-back.
- Latency for non-memory instructions: 1 cycle to `wb_valid`.
- Latency for memory instructions: 2 cycles plus the number of wait cycles from `mem_req` rising to `mem_ack`.
  - With `mem_ack` in the first ACCESS cycle, `wb_valid` is 3 cycles after `valid_in`.
- `valid_in` is ignored while state≠IDLE. Upstream is held by `stall`, so the instruction is re-presented.
- `mem_ack` outside ACCESS is ignored.
- A timeout and `mem_ack` in the same cycle resolve as ack: no `bus_err`.
- `Wdata` holds its value between `wb_valid` pulses.

## Structure
- Shared package: the load/store opcode constants alongside the existing opcode set, state encoding, and lane-size enum (BYTE/HALF/WORD).
- One sub-module, `mem_lane`: combinational store-lane alignment, byte-enable generation, and load extraction/extension.
- The FSM, timeout counter and output registers live in `mem_stage`.

## Test plan
- ADDU result 0x1234_5678 with `valid_in`: next cycle `wb_valid`=1, `Wdata`=0x1234_5678, `mem_req` never high.
- LB at 0x0000_0101 with `mem_rdata`=0x11F2_3344 and immediate ack:
  - Bus shows `mem_addr`=0x100, `be`=4'b0100.
  - `Wdata`=0xFFFF_FFF2; the same read as LBU gives 0x0000_00F2.
- SH at 0x202 with `Rdata2`=0xAAAA_BEEF: `mem_we`=1, `be`=4'b0011, `mem_wdata`=0xBEEF_BEEF; `stall` high until DONE.
- LW at 0x0000_0006: `addr_err` pulse, `Wdata`=0, no `mem_req`.
- LW with `mem_ack` withheld for `TIMEOUT` cycles: `bus_err` pulse, `Wdata`=0, FSM returns to IDLE.
  - Repeat with ack arriving 3 cycles after request: `wb_valid` 5 cycles after `valid_in`.
- `RST` pulsed during ACCESS: `mem_req`=0 within the same cycle, no `wb_valid`; next load completes normally.
